// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer for a flappy-bird style game.
// Decodes PS/2 flap key presses, runs bird physics once per frame, keeps a
// saturating 3-digit BCD score and walks IDLE -> PLAY -> DYING -> OVER.
// Optional feature: define GAME_HISCORE_EN to add the hiscore output/register.
module game_ctrl #(
  parameter logic [7:0] FLAP_KEY     = 8'h29,
  parameter int          Y_START      = 240,
  parameter int          Y_MAX        = 463,
  parameter int          GRAVITY      = 1,
  parameter int          FLAP_VEL     = 8,
  parameter int          VMAX         = 12,
  parameter int          DEATH_FRAMES = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        collide,
  input  logic        pipe_pass,
  output logic [1:0]  state,
  output logic [8:0]  bird_y,
  output logic        scroll_en,
`ifdef GAME_HISCORE_EN
  output logic [11:0] score,
  output logic [11:0] hiscore
`else
  output logic [11:0] score
`endif
);

  localparam int DW = $clog2(DEATH_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t            st;
  logic signed [5:0] vel;
  logic [DW-1:0]     dcnt;
  logic              break_pending;
  logic              flap_req;

  logic              key_flap;
  logic              flap_now;
  logic signed [6:0] vel_sum;
  logic signed [5:0] vel_grav;
  logic signed [5:0] vel_next;
  logic signed [5:0] vel_fr;
  logic signed [9:0] y_sum;
  logic [8:0]        y_clamp;
  logic              at_floor;
  logic              death_done;
  logic              enter_over;
  logic [11:0]       score_inc;

  assign state = st;

  // Key decode: a make code counts as a flap in the same cycle it arrives,
  // so a key coinciding with frame_tick is seen by that tick.
  always_comb begin
    key_flap = key_valid && !break_pending && (key_code != 8'hF0) &&
               (key_code != 8'hE0) && (key_code == FLAP_KEY);
    flap_now = flap_req || key_flap;
  end

  // Break-code tracking and the flap request latch (cleared by every tick).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      break_pending <= 1'b0;
      flap_req      <= 1'b0;
    end else begin
      if (key_valid) begin
        if (key_code == 8'hF0)
          break_pending <= 1'b1;
        else if (key_code != 8'hE0)
          break_pending <= 1'b0;
      end
      if (frame_tick)
        flap_req <= 1'b0;
      else if (key_flap)
        flap_req <= 1'b1;
    end
  end

  // Per-frame physics: velocity update, then 10-bit signed position clamp.
  always_comb begin
    vel_sum  = 7'(vel) + 7'(GRAVITY);
    vel_grav = (vel_sum > 7'(VMAX)) ? 6'(VMAX) : vel_sum[5:0];
    vel_next = flap_now ? 6'(-FLAP_VEL) : vel_grav;
    vel_fr   = (st == S_DYING) ? vel_grav : vel_next;
    y_sum    = $signed({1'b0, bird_y}) + 10'(vel_fr);
    if (y_sum < 10'sd0)
      y_clamp = 9'd0;
    else if (y_sum > 10'(Y_MAX))
      y_clamp = 9'(Y_MAX);
    else
      y_clamp = y_sum[8:0];
    at_floor   = (y_clamp == 9'(Y_MAX));
    death_done = (dcnt == DW'(DEATH_FRAMES - 1));
    enter_over = (st == S_DYING) &&
                 ((bird_y == 9'(Y_MAX)) || (frame_tick && (at_floor || death_done)));
  end

  // BCD score increment with decimal carry, holding at 999.
  always_comb begin
    score_inc = score;
    if (score != 12'h999) begin
      if (score[3:0] != 4'd9) begin
        score_inc[3:0] = score[3:0] + 4'd1;
      end else begin
        score_inc[3:0] = 4'd0;
        if (score[7:4] != 4'd9) begin
          score_inc[7:4] = score[7:4] + 4'd1;
        end else begin
          score_inc[7:4]  = 4'd0;
          score_inc[11:8] = score[11:8] + 4'd1;
        end
      end
    end
  end

  // Game FSM with registered bird position, velocity, scroll enable and score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      bird_y    <= 9'(Y_START);
      vel       <= '0;
      scroll_en <= 1'b0;
      score     <= '0;
      dcnt      <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (frame_tick && flap_now) begin
            st        <= S_PLAY;
            score     <= '0;
            vel       <= vel_next;
            bird_y    <= y_clamp;
            scroll_en <= 1'b1;
          end
        end
        S_PLAY: begin
          // Collision takes priority over both scoring and movement.
          if (collide) begin
            st        <= S_DYING;
            scroll_en <= 1'b0;
            dcnt      <= '0;
          end else begin
            if (pipe_pass)
              score <= score_inc;
            if (frame_tick) begin
              vel    <= vel_next;
              bird_y <= y_clamp;
              if (at_floor) begin
                st        <= S_DYING;
                scroll_en <= 1'b0;
                dcnt      <= '0;
              end
            end
          end
        end
        S_DYING: begin
          if (enter_over)
            st <= S_OVER;
          if (frame_tick && (bird_y != 9'(Y_MAX))) begin
            vel    <= vel_fr;
            bird_y <= y_clamp;
            dcnt   <= dcnt + 1'b1;
          end
        end
        S_OVER: begin
          if (frame_tick && flap_now) begin
            st     <= S_IDLE;
            bird_y <= 9'(Y_START);
            vel    <= '0;
            dcnt   <= '0;
          end
        end
      endcase
    end
  end

`ifdef GAME_HISCORE_EN
  // High score captured on entry to OVER; BCD digits compare as plain binary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hiscore <= '0;
    else if (enter_over && (score > hiscore))
      hiscore <= score;
  end
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl. A behavioural game
// model predicts outputs per cycle; predictions are queued and compared after
// each clock edge.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        collide = 1'b0;
  logic        pipe_pass = 1'b0;
  logic [1:0]  state;
  logic [8:0]  bird_y;
  logic        scroll_en;
  logic [11:0] score;
`ifdef GAME_HISCORE_EN
  logic [11:0] hiscore;
`endif

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .key_valid (key_valid),
    .key_code  (key_code),
    .collide   (collide),
    .pipe_pass (pipe_pass),
    .state     (state),
    .bird_y    (bird_y),
    .scroll_en (scroll_en),
`ifdef GAME_HISCORE_EN
    .score     (score),
    .hiscore   (hiscore)
`else
    .score     (score)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [8:0]  y;
    logic        sc;
    logic [11:0] score;
    logic [11:0] hi;
  } exp_t;
  exp_t sb[$];

  // Behavioural model state (0 IDLE, 1 PLAY, 2 DYING, 3 OVER).
  int m_st, m_y, m_v, m_n, m_hi, m_dc;
  bit m_sc, m_freq;

  function automatic logic [11:0] bcd(int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic void model_reset();
    m_st = 0; m_y = 240; m_v = 0; m_n = 0; m_hi = 0; m_dc = 0;
    m_sc = 0; m_freq = 0;
  endfunction

  function automatic void model_over();
    m_st = 3;
    if (m_n > m_hi) m_hi = m_n;
  endfunction

  function automatic void model_move(bit flap);
    if (flap) m_v = -8;
    else if (m_v + 1 > 12) m_v = 12;
    else m_v = m_v + 1;
    m_y = m_y + m_v;
    if (m_y < 0) m_y = 0;
    if (m_y > 463) m_y = 463;
  endfunction

  function automatic void model_cycle(bit tk, bit kf, bit pp, bit col);
    bit fnow;
    fnow = m_freq | kf;
    case (m_st)
      0: if (tk && fnow) begin
           m_st = 1; m_n = 0; m_sc = 1;
           model_move(1'b1);
         end
      1: if (col) begin
           m_st = 2; m_sc = 0; m_dc = 0;
         end else begin
           if (pp && m_n < 999) m_n = m_n + 1;
           if (tk) begin
             model_move(fnow);
             if (m_y == 463) begin m_st = 2; m_sc = 0; m_dc = 0; end
           end
         end
      2: if (m_y == 463) model_over();
         else if (tk) begin
           model_move(1'b0);
           m_dc = m_dc + 1;
           if (m_y == 463 || m_dc == 90) model_over();
         end
      default: if (tk && fnow) begin
           m_st = 0; m_y = 240; m_v = 0;
         end
    endcase
    if (tk) m_freq = 0;
    else if (kf) m_freq = 1;
  endfunction

  function automatic void push(string tag);
    exp_t e;
    e.tag = tag; e.st = 2'(m_st); e.y = 9'(m_y); e.sc = m_sc;
    e.score = bcd(m_n); e.hi = bcd(m_hi);
    sb.push_back(e);
  endfunction

  task automatic cmp(string tag, string what, logic [11:0] obs, logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "state",  12'(state),     12'(e.st));
    cmp(e.tag, "bird_y", 12'(bird_y),    12'(e.y));
    cmp(e.tag, "scroll", 12'(scroll_en), 12'(e.sc));
    cmp(e.tag, "score",  score,          e.score);
`ifdef GAME_HISCORE_EN
    cmp(e.tag, "hiscore", hiscore, e.hi);
`endif
  endtask

  task automatic drive(string tag, bit tk, bit kv, logic [7:0] code, bit kf,
                       bit pp, bit col);
    frame_tick = tk; key_valid = kv; key_code = code;
    pipe_pass = pp; collide = col;
    model_cycle(tk, kf, pp, col);
    push(tag);
    @(posedge clk);
    #1;
    frame_tick = 1'b0; key_valid = 1'b0; key_code = 8'h00;
    pipe_pass = 1'b0; collide = 1'b0;
    check();
  endtask

  task automatic play_one_game(string tag, int passes);
    drive({tag, "_start"}, 1, 1, 8'h29, 1, 0, 0);
    for (int i = 0; i < passes; i++) drive({tag, "_pipe"}, 0, 0, 8'h00, 0, 1, 0);
    drive({tag, "_collide"}, 0, 0, 8'h00, 0, 0, 1);
    // Flap while dying must be ignored.
    drive({tag, "_dyflap"}, 1, 1, 8'h29, 1, 0, 0);
    for (int i = 0; i < 100 && m_st == 2; i++) drive({tag, "_fall"}, 1, 0, 8'h00, 0, 0, 0);
    cmp(tag, "reached_over", 12'(state), 12'd3);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push("reset");
    check();

    // Same-cycle key + tick starts the game with an immediate flap.
    drive("start", 1, 1, 8'h29, 1, 0, 0);
    cmp("start", "y232", 12'(bird_y), 12'd232);

    // Break sequence suppresses the flap; E0 is transparent; next 29 flaps.
    drive("brk_f0",  0, 1, 8'hF0, 0, 0, 0);
    drive("brk_29",  0, 1, 8'h29, 0, 0, 0);
    drive("tick_nf", 1, 0, 8'h00, 0, 0, 0);
    drive("e0",      0, 1, 8'hE0, 0, 0, 0);
    drive("key29",   0, 1, 8'h29, 1, 0, 0);
    drive("tick_fl", 1, 0, 8'h00, 0, 0, 0);

    // BCD scoring with decimal carry and saturation.
    for (int i = 0; i < 99; i++) drive("pipe", 0, 0, 8'h00, 0, 1, 0);
    cmp("score", "099", score, 12'h099);
    drive("pipe_carry", 0, 0, 8'h00, 0, 1, 0);
    cmp("score", "100", score, 12'h100);
    for (int i = 0; i < 899; i++) drive("pipe", 0, 0, 8'h00, 0, 1, 0);
    cmp("score", "999", score, 12'h999);
    drive("pipe_sat", 0, 0, 8'h00, 0, 1, 0);
    cmp("score", "999_hold", score, 12'h999);

    // Collision beats a simultaneous pipe pass.
    drive("pp_col", 0, 0, 8'h00, 0, 1, 1);

    // Asynchronous reset while dying, checked before any clock edge.
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    push("async_rst");
    check();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive("post_rst", 0, 0, 8'h00, 0, 0, 0);

    // Free fall to the floor: velocity saturates, bird clamps, DYING then OVER.
    drive("start2", 1, 1, 8'h29, 1, 0, 0);
    for (int i = 0; i < 100 && m_st == 1; i++) drive("fall", 1, 0, 8'h00, 0, 0, 0);
    cmp("fall", "dying", 12'(state), 12'd2);
    cmp("fall", "floor", 12'(bird_y), 12'd463);
    drive("to_over", 0, 0, 8'h00, 0, 0, 0);
    drive("over_hold", 1, 0, 8'h00, 0, 0, 0);
    drive("over_key", 0, 1, 8'h29, 1, 0, 0);
    drive("over_idle", 1, 0, 8'h00, 0, 0, 0);

    // Two scored games: 5 then 3.
    play_one_game("g5", 5);
`ifdef GAME_HISCORE_EN
    cmp("g5", "hiscore005", hiscore, 12'h005);
`endif
    drive("g5_idle", 1, 1, 8'h29, 1, 0, 0);
    play_one_game("g3", 3);
`ifdef GAME_HISCORE_EN
    cmp("g3", "hiscore005", hiscore, 12'h005);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
